sysclk_mmcm_ctrl: RTL and testbench

Supervisor and fine-phase-shift sequencer for the SYSCLK MMCM. It holds the MMCM in reset after power-up or on request and waits for lock, retrying on timeout. It recovers automatically from loss of lock. Once locked it executes signed multi-step fine phase-shift requests over the MMCM PSEN/PSINCDEC/PSDONE handshake, tracking the cumulative phase position. It runs on a free-running clock that also drives the MMCM PSCLK, so it keeps operating while SYSCLK is absent.

---
 rtl/sysclk_ctrl_pkg.sv | 21 ++
 rtl/sysclk_mmcm_ctrl_if.sv | 11 +
 rtl/sysclk_mmcm_ctrl_sync_2ff.sv | 19 +
 rtl/sysclk_mmcm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sysclk_mmcm_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysclk_ctrl_pkg.sv
// Shared types and constants for the SYSCLK MMCM supervisor.
package sysclk_ctrl_pkg;

  localparam int unsigned RELOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    IDLE,
    PS_PULSE,
    PS_WAIT
  } ctrl_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sysclk_mmcm_ctrl_if.sv
// Phase-shift request handshake between a requester and the MMCM supervisor.
interface sysclk_mmcm_ctrl_if #(
  parameter int unsigned STEP_W = 10
);
  logic              ps_valid_i;
  logic [STEP_W-1:0] ps_steps_i;
  logic              ps_ready_o;

  modport master (output ps_valid_i, output ps_steps_i, input ps_ready_o);
  modport slave  (input ps_valid_i, input ps_steps_i, output ps_ready_o);
endinterface

// File: rtl/sysclk_mmcm_ctrl_sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sysclk_mmcm_ctrl.sv
// SYSCLK MMCM supervisor: reset/lock sequencing, relock recovery and
// multi-step fine phase shifting over PSEN/PSINCDEC/PSDONE.
module sysclk_mmcm_ctrl
  import sysclk_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned PS_TIMEOUT   = 255,
  parameter int unsigned STEP_W       = 10,
  parameter int unsigned POS_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mmcm_locked_i,
  output logic                    mmcm_rst_o,
  output logic                    ps_en_o,
  output logic                    ps_incdec_o,
  input  logic                    ps_done_i,
  input  logic                    relock_i,
  sysclk_mmcm_ctrl_if.slave       ps_if,
  output logic                    locked_o,
  output logic                    busy_o,
  output logic [POS_W-1:0]        phase_pos_o,
  output logic [RELOCK_CNT_W-1:0] relock_count_o,
  output logic                    ps_timeout_o,
  input  logic                    clear_err_i
);

  localparam int unsigned TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, PS_TIMEOUT);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RST_LOAD  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PS_LOAD   = TMR_W'(PS_TIMEOUT - 1);

  ctrl_state_e       state;
  logic [TMR_W-1:0]  tmr;
  logic [STEP_W-1:0] steps_left;
  logic              ready_q;
  logic              lock_s;

  logic [STEP_W-1:0] req_steps;
  logic [STEP_W-1:0] req_mag;
  logic              req_neg;
  logic              req_zero;
  logic              lost_lock;
  logic              lock_expired;
  logic              go_rst;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (mmcm_locked_i),
    .q     (lock_s)
  );

  assign ps_if.ps_ready_o = ready_q;

  always_comb begin
    req_steps = ps_if.ps_steps_i;
    req_neg   = req_steps[STEP_W-1];
    req_zero  = (req_steps == '0);
    // most-negative request maps to 2^(STEP_W-1), which still fits unsigned
    req_mag   = req_neg ? ((~req_steps) + STEP_W'(1)) : req_steps;
  end

  always_comb begin
    lost_lock    = !lock_s && (state inside {IDLE, PS_PULSE, PS_WAIT});
    lock_expired = (state == WAIT_LOCK) && !lock_s && (tmr == '0);
    go_rst       = (state != RST_HOLD) && (relock_i || lost_lock || lock_expired);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RST_HOLD;
      tmr            <= RST_LOAD;
      steps_left     <= '0;
      mmcm_rst_o     <= 1'b1;
      ps_en_o        <= 1'b0;
      ps_incdec_o    <= 1'b0;
      ready_q        <= 1'b0;
      locked_o       <= 1'b0;
      busy_o         <= 1'b0;
      phase_pos_o    <= '0;
      relock_count_o <= '0;
      ps_timeout_o   <= 1'b0;
    end else begin
      if (clear_err_i) ps_timeout_o <= 1'b0;

      if (go_rst) begin
        state       <= RST_HOLD;
        tmr         <= RST_LOAD;
        steps_left  <= '0;
        mmcm_rst_o  <= 1'b1;
        ps_en_o     <= 1'b0;
        ready_q     <= 1'b0;
        locked_o    <= 1'b0;
        busy_o      <= 1'b0;
        phase_pos_o <= '0;
        if (relock_count_o != '1) relock_count_o <= relock_count_o + RELOCK_CNT_W'(1);
      end else begin
        unique case (state)
          RST_HOLD: begin
            if (tmr == '0) begin
              state      <= WAIT_LOCK;
              tmr        <= LOCK_LOAD;
              mmcm_rst_o <= 1'b0;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              state    <= IDLE;
              locked_o <= 1'b1;
              ready_q  <= 1'b1;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          IDLE: begin
            if (ps_if.ps_valid_i && !req_zero) begin
              state       <= PS_PULSE;
              ps_en_o     <= 1'b1;
              ps_incdec_o <= !req_neg;
              steps_left  <= req_mag;
              ready_q     <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          PS_PULSE: begin
            state   <= PS_WAIT;
            ps_en_o <= 1'b0;
            tmr     <= PS_LOAD;
          end
          PS_WAIT: begin
            if (ps_done_i) begin
              phase_pos_o <= ps_incdec_o ? (phase_pos_o + POS_W'(1))
                                         : (phase_pos_o - POS_W'(1));
              steps_left  <= steps_left - STEP_W'(1);
              if (steps_left == STEP_W'(1)) begin
                state   <= IDLE;
                ready_q <= 1'b1;
                busy_o  <= 1'b0;
              end else begin
                state   <= PS_PULSE;
                ps_en_o <= 1'b1;
              end
            end else if (tmr == '0) begin
              state        <= IDLE;
              steps_left   <= '0;
              ready_q      <= 1'b1;
              busy_o       <= 1'b0;
              ps_timeout_o <= 1'b1;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          default: state <= RST_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysclk_mmcm_ctrl.sv
// Directed/randomized bench for sysclk_mmcm_ctrl with a phase/relock model.
module tb_sysclk_mmcm_ctrl;

  localparam int unsigned RST_CYCLES   = 16;
  localparam int unsigned LOCK_TIMEOUT = 100;
  localparam int unsigned PS_TIMEOUT   = 20;
  localparam int unsigned STEP_W       = 10;
  localparam int unsigned POS_W        = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mmcm_locked_i = 1'b0;
  logic ps_done_i = 1'b0;
  logic relock_i = 1'b0;
  logic clear_err_i = 1'b0;
  logic mmcm_rst_o, ps_en_o, ps_incdec_o, locked_o, busy_o, ps_timeout_o;
  logic [POS_W-1:0] phase_pos_o;
  logic [7:0] relock_count_o;

  sysclk_mmcm_ctrl_if #(.STEP_W(STEP_W)) ps_if ();

  sysclk_mmcm_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .PS_TIMEOUT   (PS_TIMEOUT),
    .STEP_W       (STEP_W),
    .POS_W        (POS_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mmcm_locked_i  (mmcm_locked_i),
    .mmcm_rst_o     (mmcm_rst_o),
    .ps_en_o        (ps_en_o),
    .ps_incdec_o    (ps_incdec_o),
    .ps_done_i      (ps_done_i),
    .relock_i       (relock_i),
    .ps_if          (ps_if),
    .locked_o       (locked_o),
    .busy_o         (busy_o),
    .phase_pos_o    (phase_pos_o),
    .relock_count_o (relock_count_o),
    .ps_timeout_o   (ps_timeout_o),
    .clear_err_i    (clear_err_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int psen_count = 0;
  int exp_pos = 0;
  int exp_relock = 0;
  int pos_mask = (1 << POS_W) - 1;
  bit req_dir = 1'b0;

  always @(posedge clk) if (ps_en_o === 1'b1) psen_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_psen();
    int w = 0;
    while (ps_en_o !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("psen_seen", ps_en_o, 1);
  endtask

  task automatic start_req(input int steps);
    chk("ready_before", ps_if.ps_ready_o, 1);
    ps_if.ps_valid_i = 1'b1;
    ps_if.ps_steps_i = STEP_W'(steps);
    req_dir = (steps > 0);
    @(negedge clk);
    ps_if.ps_valid_i = 1'b0;
    ps_if.ps_steps_i = '0;
    chk("ready_after_accept", ps_if.ps_ready_o, steps == 0);
    chk("busy_after_accept", busy_o, steps != 0);
  endtask

  task automatic do_step(input int delay);
    wait_psen();
    chk("incdec", ps_incdec_o, req_dir);
    @(negedge clk);
    chk("psen_single", ps_en_o, 0);
    repeat (delay - 1) @(negedge clk);
    ps_done_i = 1'b1;
    @(negedge clk);
    ps_done_i = 1'b0;
    exp_pos += req_dir ? 1 : -1;
  endtask

  task automatic shift(input int steps, input int delay);
    int n0 = psen_count;
    int n = (steps < 0) ? -steps : steps;
    start_req(steps);
    for (int k = 0; k < n; k++)
      do_step((delay != 0) ? delay : int'($urandom_range(1, 14)));
    chk("phase_pos", phase_pos_o, exp_pos & pos_mask);
    chk("busy_end", busy_o, 0);
    chk("ready_end", ps_if.ps_ready_o, 1);
    chk("psen_pulses", psen_count - n0, n);
  endtask

  // Starts on the first cycle of an mmcm_rst_o pulse; optionally pokes relock_i mid-hold.
  task automatic bring_up(input int lock_delay, input bit poke_relock);
    int n = 0;
    while (mmcm_rst_o === 1'b1 && n < 1000) begin
      relock_i = poke_relock && (n == 5);
      n++;
      @(negedge clk);
    end
    relock_i = 1'b0;
    chk("rst_len", n, RST_CYCLES);
    repeat (lock_delay) @(negedge clk);
    mmcm_locked_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("locked_early", locked_o, 0);
    @(negedge clk);
    chk("locked", locked_o, 1);
    chk("ready_locked", ps_if.ps_ready_o, 1);
    chk("rst_low_locked", mmcm_rst_o, 0);
    chk("relock_cnt", relock_count_o, exp_relock);
    chk("phase_zero", phase_pos_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    int n1;
    ps_if.ps_valid_i = 1'b0;
    ps_if.ps_steps_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mmcm_rst", mmcm_rst_o, 1);
    chk("rst_psen", ps_en_o, 0);
    chk("rst_incdec", ps_incdec_o, 0);
    chk("rst_ready", ps_if.ps_ready_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_phase", phase_pos_o, 0);
    chk("rst_relock", relock_count_o, 0);
    chk("rst_timeout", ps_timeout_o, 0);
    reset_n = 1'b1;

    // Power-up: rst for cycles 0..15, lock at cycle 40, locked at 43
    bring_up(40 - RST_CYCLES, 1'b0);

    // +5 then -3 with PSDONE 12 cycles after each PSEN
    shift(5, 12);
    shift(-3, 12);
    chk("phase_two", phase_pos_o, 2);

    // Random small requests, including zero
    for (int i = 0; i < 4; i++) shift(int'($urandom_range(12)) - 6, 0);

    // PSDONE withheld -> timeout
    n0 = psen_count;
    start_req(3);
    wait_psen();
    repeat (PS_TIMEOUT) @(negedge clk);
    chk("timeout_not_yet", ps_timeout_o, 0);
    chk("busy_waiting", busy_o, 1);
    @(negedge clk);
    chk("timeout_set", ps_timeout_o, 1);
    chk("timeout_idle_busy", busy_o, 0);
    chk("timeout_idle_ready", ps_if.ps_ready_o, 1);
    chk("timeout_phase", phase_pos_o, exp_pos & pos_mask);
    repeat (5) @(negedge clk);
    chk("timeout_one_psen", psen_count - n0, 1);
    chk("timeout_sticky", ps_timeout_o, 1);
    clear_err_i = 1'b1;
    @(negedge clk);
    clear_err_i = 1'b0;
    chk("timeout_cleared", ps_timeout_o, 0);

    // Stray PSDONE in IDLE
    n0 = psen_count;
    ps_done_i = 1'b1;
    @(negedge clk);
    ps_done_i = 1'b0;
    @(negedge clk);
    chk("stray_done_phase", phase_pos_o, exp_pos & pos_mask);
    chk("stray_done_busy", busy_o, 0);

    // Zero request: accepted, no PSEN
    start_req(0);
    repeat (5) @(negedge clk);
    chk("zero_no_psen", psen_count - n0, 0);
    chk("zero_phase", phase_pos_o, exp_pos & pos_mask);

    // relock_i in IDLE at phase 7, then lock never returns -> lock timeout
    shift(7 - exp_pos, 0);
    chk("phase_seven", phase_pos_o, 7);
    relock_i = 1'b1;
    @(negedge clk);
    relock_i = 1'b0;
    mmcm_locked_i = 1'b0;
    exp_relock++;
    exp_pos = 0;
    chk("relock_rst", mmcm_rst_o, 1);
    chk("relock_phase", phase_pos_o, 0);
    chk("relock_cnt1", relock_count_o, exp_relock);
    chk("relock_unlocked", locked_o, 0);
    n = 0;
    while (mmcm_rst_o === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    chk("relock_rst_len", n, RST_CYCLES);
    n = 0;
    while (mmcm_rst_o === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    chk("lock_timeout_len", n, LOCK_TIMEOUT);
    exp_relock++;
    chk("lock_timeout_cnt", relock_count_o, exp_relock);
    bring_up(int'($urandom_range(0, 60)), 1'b1);

    // Extreme requests: most negative and most positive step counts
    shift(-512, 1);
    shift(511, 1);
    chk("phase_wrap_neg1", phase_pos_o, 16'hFFFF);

    // Lock drops during the third step of +8
    shift(-exp_pos, 0);
    n0 = psen_count;
    start_req(8);
    do_step(int'($urandom_range(1, 14)));
    do_step(int'($urandom_range(1, 14)));
    wait_psen();
    @(negedge clk);
    mmcm_locked_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_not_yet", mmcm_rst_o, 0);
    chk("drop_busy", busy_o, 1);
    @(negedge clk);
    exp_relock++;
    exp_pos = 0;
    chk("drop_rst", mmcm_rst_o, 1);
    chk("drop_phase", phase_pos_o, 0);
    chk("drop_busy_clr", busy_o, 0);
    chk("drop_unlocked", locked_o, 0);
    chk("drop_cnt", relock_count_o, exp_relock);
    n1 = psen_count;
    chk("drop_psen_before", n1 - n0, 3);
    bring_up(int'($urandom_range(0, 60)), 1'b0);
    chk("drop_no_more_psen", psen_count - n1, 0);

    shift(3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
